// File: rtl/tomasula_types.sv
// Shared types for the out-of-order core's reservation stations.
// Holds the dispatched control word, the ALU issue packet, the station
// state encoding and the ROB tag width that the stations default from.
package tomasula_types;

  localparam int ROB_TAG_W = 3;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  typedef enum logic [1:0] {
    RS_IDLE  = ST_IDLE,
    RS_WAIT  = ST_WAIT,
    RS_READY = ST_READY
  } rs_state_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  src1_reg;
    logic [4:0]  src2_reg;
    logic        src2_valid;
    logic [31:0] src2_data;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
  } ctl_word;

  typedef struct packed {
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob_tag;
  } rs_issue_t;

endpackage

// File: rtl/res_station_if.sv
// Bundle between a reservation station and its neighbours: dispatch
// handshake from the instruction queue, register/ROB operand lookups,
// the CDB broadcast, and the valid/ready issue handshake toward the ALU.
// The station side uses modport slave; the surrounding pipeline uses master.
interface res_station_if #(
  parameter int ROB_TAG_W = tomasula_types::ROB_TAG_W
);
  import tomasula_types::*;

  logic                 load_i;
  ctl_word              ctl_i;
  logic [ROB_TAG_W-1:0] rob_tag_i;
  logic                 rs1_ready_i;
  logic [31:0]          rs1_data_i;
  logic [ROB_TAG_W-1:0] rs1_tag_i;
  logic                 rs2_ready_i;
  logic [31:0]          rs2_data_i;
  logic [ROB_TAG_W-1:0] rs2_tag_i;
  logic                 cdb_valid_i;
  logic [ROB_TAG_W-1:0] cdb_tag_i;
  logic [31:0]          cdb_data_i;
  logic                 empty_o;
  logic                 issue_valid_o;
  logic                 issue_ready_i;
  rs_issue_t            issue_o;

  modport slave (
    input  load_i, ctl_i, rob_tag_i,
    input  rs1_ready_i, rs1_data_i, rs1_tag_i,
    input  rs2_ready_i, rs2_data_i, rs2_tag_i,
    input  cdb_valid_i, cdb_tag_i, cdb_data_i,
    input  issue_ready_i,
    output empty_o, issue_valid_o, issue_o
  );

  modport master (
    output load_i, ctl_i, rob_tag_i,
    output rs1_ready_i, rs1_data_i, rs1_tag_i,
    output rs2_ready_i, rs2_data_i, rs2_tag_i,
    output cdb_valid_i, cdb_tag_i, cdb_data_i,
    output issue_ready_i,
    input  empty_o, issue_valid_o, issue_o
  );

endinterface

// File: rtl/rs_operand.sv
// One source operand slot of a reservation station.
// Captures either a ready value or a ROB tag at load time, snoops the CDB
// for the pending tag, and reports its next-cycle pending flag so the
// owning FSM can move to READY in the same cycle the value arrives.
// Ports: clk/rst_n; flush_i clears pending; load_i (already qualified by
// the FSM); capture_en_i enables CDB snooping; src_* lookup result;
// cdb_* broadcast; pending_d_o next pending flag; data_o held value.
module rs_operand #(
  parameter int TAG_W = tomasula_types::ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             capture_en_i,
  input  logic             src_ready_i,
  input  logic [31:0]      src_data_i,
  input  logic [TAG_W-1:0] src_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic             pending_d_o,
  output logic [31:0]      data_o
);

  logic             pending_q, pending_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  // Load-cycle bypass: the value may be on the CDB in the very cycle the
  // tag is looked up, so the incoming tag is compared, not the stored one.
  always_comb begin
    pending_d = pending_q;
    tag_d     = tag_q;
    data_d    = data_q;
    if (flush_i) begin
      pending_d = 1'b0;
    end else if (load_i) begin
      tag_d = src_tag_i;
      if (src_ready_i) begin
        pending_d = 1'b0;
        data_d    = src_data_i;
      end else if (cdb_valid_i && (cdb_tag_i == src_tag_i)) begin
        pending_d = 1'b0;
        data_d    = cdb_data_i;
      end else begin
        pending_d = 1'b1;
      end
    end else if (capture_en_i && pending_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
      pending_d = 1'b0;
      data_d    = cdb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  assign pending_d_o = pending_d;
  assign data_o      = data_q;

endmodule

// File: rtl/res_station.sv
// Single-entry reservation station. Accepts one dispatched operation when
// empty, waits on the CDB for missing operands, then presents the full
// packet to the ALU until accepted.
// Ports: clk, rst_n (async active-low), flush_i (discard entry), and rs,
// the slave side of res_station_if (dispatch, operand lookups, CDB, issue).
module res_station #(
  parameter int ROB_TAG_W = tomasula_types::ROB_TAG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  res_station_if.slave  rs
);
  import tomasula_types::*;

  rs_state_e            state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [6:0]           funct7_q, funct7_d;
  logic [31:0]          pc_q, pc_d;
  logic [ROB_TAG_W-1:0] rob_tag_q, rob_tag_d;

  logic        load_fire;
  logic        capture_en;
  logic        op1_pending_d, op2_pending_d;
  logic [31:0] op1_data, op2_data;
  logic        op2_src_ready;
  logic [31:0] op2_src_data;

  // Register numbers are only needed by the lookup logic upstream.
  logic unused_src_regs;
  assign unused_src_regs = &{1'b0, rs.ctl_i.src1_reg, rs.ctl_i.src2_reg};

  assign load_fire  = rs.load_i && (state_q == RS_IDLE) && !flush_i;
  assign capture_en = (state_q == RS_WAIT);

  // An immediate second operand is ready by construction and wins over the
  // register lookup.
  assign op2_src_ready = rs.ctl_i.src2_valid || rs.rs2_ready_i;
  assign op2_src_data  = rs.ctl_i.src2_valid ? rs.ctl_i.src2_data : rs.rs2_data_i;

  rs_operand #(.TAG_W(ROB_TAG_W)) u_op1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .load_i       (load_fire),
    .capture_en_i (capture_en),
    .src_ready_i  (rs.rs1_ready_i),
    .src_data_i   (rs.rs1_data_i),
    .src_tag_i    (rs.rs1_tag_i),
    .cdb_valid_i  (rs.cdb_valid_i),
    .cdb_tag_i    (rs.cdb_tag_i),
    .cdb_data_i   (rs.cdb_data_i),
    .pending_d_o  (op1_pending_d),
    .data_o       (op1_data)
  );

  rs_operand #(.TAG_W(ROB_TAG_W)) u_op2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .load_i       (load_fire),
    .capture_en_i (capture_en),
    .src_ready_i  (op2_src_ready),
    .src_data_i   (op2_src_data),
    .src_tag_i    (rs.rs2_tag_i),
    .cdb_valid_i  (rs.cdb_valid_i),
    .cdb_tag_i    (rs.cdb_tag_i),
    .cdb_data_i   (rs.cdb_data_i),
    .pending_d_o  (op2_pending_d),
    .data_o       (op2_data)
  );

  // Flush has priority over load, wakeup and issue.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = RS_IDLE;
    end else begin
      case (state_q)
        RS_IDLE: begin
          if (rs.load_i) begin
            state_d = (op1_pending_d || op2_pending_d) ? RS_WAIT : RS_READY;
          end
        end
        RS_WAIT: begin
          if (!op1_pending_d && !op2_pending_d) begin
            state_d = RS_READY;
          end
        end
        RS_READY: begin
          if (rs.issue_ready_i) begin
            state_d = RS_IDLE;
          end
        end
        default: state_d = RS_IDLE;
      endcase
    end
  end

  always_comb begin
    op_d      = op_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    pc_d      = pc_q;
    rob_tag_d = rob_tag_q;
    if (load_fire) begin
      op_d      = rs.ctl_i.op;
      funct3_d  = rs.ctl_i.funct3;
      funct7_d  = rs.ctl_i.funct7;
      pc_d      = rs.ctl_i.pc;
      rob_tag_d = rs.rob_tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RS_IDLE;
      op_q      <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      pc_q      <= '0;
      rob_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      pc_q      <= pc_d;
      rob_tag_q <= rob_tag_d;
    end
  end

  assign rs.empty_o       = (state_q == RS_IDLE);
  assign rs.issue_valid_o = (state_q == RS_READY);
  assign rs.issue_o       = '{op:      op_q,
                              funct3:  funct3_q,
                              funct7:  funct7_q,
                              a:       op1_data,
                              b:       op2_data,
                              pc:      pc_q,
                              rob_tag: rob_tag_q};

endmodule

// File: tb/tb_res_station.sv
// Self-checking bench for res_station: directed scenarios followed by a
// randomized run against a behavioural model of the single entry.
module tb_res_station;
  import tomasula_types::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  res_station_if #(.ROB_TAG_W(ROB_TAG_W)) bus ();

  res_station #(.ROB_TAG_W(ROB_TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .rs      (bus)
  );

  // Behavioural model: one entry that is either free or holds an operation
  // whose two operands are each known (value) or awaited (tag).
  bit          mOcc, mAK, mBK;
  logic [31:0] mA, mB, mPC;
  logic [2:0]  mAT, mBT, mTag, mF3;
  logic [6:0]  mOp, mF7;

  function automatic rs_issue_t model_issue();
    rs_issue_t e;
    e.op = mOp; e.funct3 = mF3; e.funct7 = mF7;
    e.a = mA; e.b = mB; e.pc = mPC; e.rob_tag = mTag;
    return e;
  endfunction

  function automatic bit model_valid();
    return mOcc && mAK && mBK;
  endfunction

  task automatic model_step();
    bit hitA, hitB;
    if (!rst_n) begin
      mOcc = 0; mAK = 0; mBK = 0;
    end else if (flush) begin
      mOcc = 0;
    end else if (!mOcc) begin
      if (bus.load_i) begin
        mOcc = 1;
        mOp = bus.ctl_i.op; mF3 = bus.ctl_i.funct3; mF7 = bus.ctl_i.funct7;
        mPC = bus.ctl_i.pc; mTag = bus.rob_tag_i;
        if (bus.rs1_ready_i) begin mAK = 1; mA = bus.rs1_data_i; end
        else if (bus.cdb_valid_i && bus.cdb_tag_i == bus.rs1_tag_i) begin mAK = 1; mA = bus.cdb_data_i; end
        else begin mAK = 0; mAT = bus.rs1_tag_i; end
        if (bus.ctl_i.src2_valid) begin mBK = 1; mB = bus.ctl_i.src2_data; end
        else if (bus.rs2_ready_i) begin mBK = 1; mB = bus.rs2_data_i; end
        else if (bus.cdb_valid_i && bus.cdb_tag_i == bus.rs2_tag_i) begin mBK = 1; mB = bus.cdb_data_i; end
        else begin mBK = 0; mBT = bus.rs2_tag_i; end
      end
    end else if (mAK && mBK) begin
      if (bus.issue_ready_i) mOcc = 0;
    end else begin
      hitA = !mAK && bus.cdb_valid_i && bus.cdb_tag_i == mAT;
      hitB = !mBK && bus.cdb_valid_i && bus.cdb_tag_i == mBT;
      if (hitA) begin mAK = 1; mA = bus.cdb_data_i; end
      if (hitB) begin mBK = 1; mB = bus.cdb_data_i; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 0;
    bus.load_i = 0; bus.ctl_i = '0; bus.rob_tag_i = '0;
    bus.rs1_ready_i = 0; bus.rs1_data_i = '0; bus.rs1_tag_i = '0;
    bus.rs2_ready_i = 0; bus.rs2_data_i = '0; bus.rs2_tag_i = '0;
    bus.cdb_valid_i = 0; bus.cdb_tag_i = '0; bus.cdb_data_i = '0;
    bus.issue_ready_i = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    tick(); tick();
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty_o); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.issue_valid_o); end
    checks++; if (bus.issue_o !== '0) begin errors++; $display("[TB] FAIL reset_issue: got %h expected 0", bus.issue_o); end
    rst_n = 1;
    tick(); tick();
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_empty: got %b expected 1", bus.empty_o); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %b expected 0", bus.issue_valid_o); end
  endtask

  task automatic test_ready_operands();
    ctl_word c;
    c = '0; c.op = OP_ADD; c.pc = 32'h100;
    bus.ctl_i = c; bus.load_i = 1; bus.rob_tag_i = 3'd3;
    bus.rs1_ready_i = 1; bus.rs1_data_i = 32'h5;
    bus.rs2_ready_i = 1; bus.rs2_data_i = 32'h7;
    bus.issue_ready_i = 1;
    tick();
    drive_idle(); bus.issue_ready_i = 1;
    checks++; if (bus.issue_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ready_valid: got %b expected 1", bus.issue_valid_o); end
    checks++; if (bus.empty_o !== 1'b0) begin errors++; $display("[TB] FAIL ready_empty: got %b expected 0", bus.empty_o); end
    checks++; if (bus.issue_o.a !== 32'h5) begin errors++; $display("[TB] FAIL ready_a: got %h expected 5", bus.issue_o.a); end
    checks++; if (bus.issue_o.b !== 32'h7) begin errors++; $display("[TB] FAIL ready_b: got %h expected 7", bus.issue_o.b); end
    checks++; if (bus.issue_o.rob_tag !== 3'd3) begin errors++; $display("[TB] FAIL ready_tag: got %0d expected 3", bus.issue_o.rob_tag); end
    checks++; if (bus.issue_o.op !== OP_ADD) begin errors++; $display("[TB] FAIL ready_op: got %h expected %h", bus.issue_o.op, OP_ADD); end
    tick();
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL ready_drain_empty: got %b expected 1", bus.empty_o); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ready_drain_valid: got %b expected 0", bus.issue_valid_o); end
  endtask

  task automatic test_cdb_wakeup();
    ctl_word c;
    drive_idle();
    c = '0; c.op = OP_ADD; c.src2_valid = 1; c.src2_data = 32'h10;
    bus.ctl_i = c; bus.load_i = 1; bus.rob_tag_i = 3'd5;
    bus.rs1_ready_i = 0; bus.rs1_tag_i = 3'd2;
    bus.rs2_ready_i = 1; bus.rs2_data_i = 32'hDEAD;
    tick();
    drive_idle();
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd4; bus.cdb_data_i = 32'h55;
    tick();
    drive_idle();
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL wake_nomatch_valid: got %b expected 0", bus.issue_valid_o); end
    checks++; if (bus.empty_o !== 1'b0) begin errors++; $display("[TB] FAIL wake_nomatch_empty: got %b expected 0", bus.empty_o); end
    tick();
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd2; bus.cdb_data_i = 32'hAA;
    tick();
    drive_idle(); bus.issue_ready_i = 1;
    checks++; if (bus.issue_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL wake_valid: got %b expected 1", bus.issue_valid_o); end
    checks++; if (bus.issue_o.a !== 32'hAA) begin errors++; $display("[TB] FAIL wake_a: got %h expected aa", bus.issue_o.a); end
    checks++; if (bus.issue_o.b !== 32'h10) begin errors++; $display("[TB] FAIL wake_b_imm: got %h expected 10", bus.issue_o.b); end
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL wake_drain_empty: got %b expected 1", bus.empty_o); end
  endtask

  task automatic test_bypass_backpressure();
    ctl_word c;
    rs_issue_t held;
    drive_idle();
    c = '0; c.op = OP_ADD; c.funct3 = 3'd2; c.pc = 32'h40;
    bus.ctl_i = c; bus.load_i = 1; bus.rob_tag_i = 3'd1;
    bus.rs1_tag_i = 3'd6; bus.rs2_tag_i = 3'd6;
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd6; bus.cdb_data_i = 32'h1234;
    tick();
    drive_idle();
    checks++; if (bus.issue_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", bus.issue_valid_o); end
    checks++; if (bus.issue_o.a !== 32'h1234) begin errors++; $display("[TB] FAIL bypass_a: got %h expected 1234", bus.issue_o.a); end
    checks++; if (bus.issue_o.b !== 32'h1234) begin errors++; $display("[TB] FAIL bypass_b: got %h expected 1234", bus.issue_o.b); end
    held = model_issue();
    for (int i = 0; i < 5; i++) begin
      c.pc = $urandom; c.op = 7'($urandom);
      bus.ctl_i = c; bus.load_i = 1; bus.rob_tag_i = 3'($urandom);
      bus.rs1_ready_i = 1; bus.rs1_data_i = $urandom;
      bus.rs2_ready_i = 1; bus.rs2_data_i = $urandom;
      bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd6; bus.cdb_data_i = $urandom;
      tick();
      checks++; if (bus.issue_o !== held) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", i, bus.issue_o, held); end
      checks++; if (bus.empty_o !== 1'b0 || bus.issue_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_flags[%0d]: got empty=%b valid=%b expected empty=0 valid=1", i, bus.empty_o, bus.issue_valid_o); end
    end
    drive_idle(); bus.issue_ready_i = 1;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
  endtask

  task automatic test_flush();
    drive_idle();
    bus.load_i = 1; bus.rob_tag_i = 3'd2;
    bus.rs1_tag_i = 3'd5; bus.rs2_tag_i = 3'd1;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b0 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait: got empty=%b valid=%b expected empty=0 valid=0", bus.empty_o, bus.issue_valid_o); end
    flush = 1; bus.issue_ready_i = 1;
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd5; bus.cdb_data_i = 32'h99;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_wait: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd5; bus.cdb_data_i = 32'h77;
    tick();
    bus.cdb_tag_i = 3'd1;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_late_cdb: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
    flush = 1; bus.load_i = 1;
    bus.rs1_ready_i = 1; bus.rs2_ready_i = 1;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_with_load: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
    tick();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_with_load_after: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
  endtask

  task automatic test_reset_midop();
    drive_idle();
    bus.load_i = 1; bus.rs1_tag_i = 3'd3; bus.rs2_ready_i = 1;
    tick();
    drive_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 3'd3;
    tick();
    drive_idle();
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_midop: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
  endtask

  task automatic test_random();
    ctl_word c;
    rs_issue_t e;
    for (int i = 0; i < 600; i++) begin
      drive_idle();
      flush = ($urandom_range(0, 31) == 0);
      bus.load_i = mOcc ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      c.op = 7'($urandom); c.src1_reg = 5'($urandom); c.src2_reg = 5'($urandom);
      c.src2_valid = ($urandom_range(0, 3) == 0); c.src2_data = $urandom;
      c.funct3 = 3'($urandom); c.funct7 = 7'($urandom); c.pc = $urandom;
      bus.ctl_i = c; bus.rob_tag_i = 3'($urandom);
      bus.rs1_ready_i = ($urandom_range(0, 2) == 0); bus.rs1_data_i = $urandom; bus.rs1_tag_i = 3'($urandom);
      bus.rs2_ready_i = ($urandom_range(0, 2) == 0); bus.rs2_data_i = $urandom; bus.rs2_tag_i = 3'($urandom);
      bus.cdb_valid_i = ($urandom_range(0, 1) == 1); bus.cdb_data_i = $urandom;
      case ($urandom_range(0, 2))
        0: bus.cdb_tag_i = mAT;
        1: bus.cdb_tag_i = mBT;
        default: bus.cdb_tag_i = 3'($urandom);
      endcase
      bus.issue_ready_i = ($urandom_range(0, 1) == 1);
      tick();
      checks++; if (bus.empty_o !== !mOcc) begin errors++; $display("[TB] FAIL rand_empty[%0d]: got %b expected %b", i, bus.empty_o, !mOcc); end
      checks++; if (bus.issue_valid_o !== model_valid()) begin errors++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", i, bus.issue_valid_o, model_valid()); end
      if (model_valid()) begin
        e = model_issue();
        checks++; if (bus.issue_o !== e) begin errors++; $display("[TB] FAIL rand_issue[%0d]: got %h expected %h", i, bus.issue_o, e); end
      end
    end
  endtask

  initial begin
    rst_n = 0;
    mOcc = 0; mAK = 0; mBK = 0; mAT = '0; mBT = '0;
    drive_idle();
    test_reset();
    test_ready_operands();
    test_cdb_wakeup();
    test_bypass_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
